// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) arbiter onto one shared memory port with fetch starvation guard
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
module mem_arbiter #(
  parameter int W = `WORD_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  output logic [W-1:0] if_rdata,
  output logic         if_ack,
  input  logic         d_load_req,
  input  logic         d_store_req,
  input  logic [W-1:0] d_addr,
  input  logic [W-1:0] d_wdata,
  output logic [W-1:0] d_rdata,
  output logic         d_ack,
  output logic         load_en,
  output logic         store_en,
  output logic [W-1:0] m_addr,
  output logic [W-1:0] m_wdata,
  input  logic [W-1:0] m_rdata,
  input  logic         m_ready,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_D, ACK} state_t;
  state_t state, state_next;
  logic [3:0] starve_cnt;
  logic ack_d;
  logic d_win;
  logic granted;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    d_win = (d_load_req | d_store_req) & ~(if_req & (starve_cnt == 4'(STARVE_MAX)));
    granted = (state == GRANT_IF || state == GRANT_D) && m_ready;
    case (state)
      IDLE:     state_next = d_win ? GRANT_D : (if_req ? GRANT_IF : IDLE);
      GRANT_IF: state_next = m_ready ? ACK : GRANT_IF;
      GRANT_D:  state_next = m_ready ? ACK : GRANT_D;
      default:  state_next = IDLE;
    endcase
  end
  assign busy   = state != IDLE;
  assign if_ack = state == ACK && !ack_d;
  assign d_ack  = state == ACK && ack_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      load_en    <= 1'b0;
      store_en   <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
      ack_d      <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (d_win) begin
          store_en   <= d_store_req;
          load_en    <= ~d_store_req;
          m_addr     <= d_addr;
          m_wdata    <= d_store_req ? d_wdata : '0;
          starve_cnt <= !if_req ? 4'd0 : (starve_cnt == 4'(STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1);
        end else if (if_req) begin
          load_en    <= 1'b1;
          store_en   <= 1'b0;
          m_addr     <= if_addr;
          m_wdata    <= '0;
          starve_cnt <= '0;
        end else begin
          starve_cnt <= '0;
        end
      end
      if (granted) begin
        load_en  <= 1'b0;
        store_en <= 1'b0;
        ack_d    <= state == GRANT_D;
        if (state == GRANT_IF) if_rdata <= m_rdata;
        else d_rdata <= store_en ? '0 : m_rdata;
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter W, default `WORD_WIDTH (32), data/address width.
REQ-002 Parameter STARVE_MAX, default 4, max consecutive data grants while fetch waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request; held until if_ack.
REQ-006 if_addr  input  W  fetch address, stable while if_req high.
REQ-007 if_rdata  output  W  fetch read data, valid while if_ack high.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_load_req  input  1  data load request; held until d_ack.
REQ-010 d_store_req  input  1  data store request; held until d_ack.
REQ-011 d_addr  input  W  data address, stable while a data request is high.
REQ-012 d_wdata  input  W  store data, stable while d_store_req high.
REQ-013 d_rdata  output  W  load data, valid while d_ack high.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 load_en  output  1  shared memory read strobe, registered.
REQ-016 store_en  output  1  shared memory write strobe, registered.
REQ-017 m_addr  output  W  shared memory address, registered.
REQ-018 m_wdata  output  W  shared memory write data, registered.
REQ-019 m_rdata  input  W  memory read data, valid when m_ready high.
REQ-020 m_ready  input  1  memory completes current access this cycle.
REQ-021 busy  output  1  high whenever state is not IDLE.

Function
REQ-022 FSM states SHALL be IDLE, GRANT_IF, GRANT_D, ACK.
REQ-023 IDLE: no request -> stay IDLE; otherwise choose winner per REQ-024, latch address/data/direction into memory-side registers, go to GRANT_IF or GRANT_D.
REQ-024 Priority: data over fetch, except fetch wins when starve_cnt == STARVE_MAX and if_req high.
REQ-025 starve_cnt (4-bit): +1 on each data grant while if_req high, saturating at STARVE_MAX; cleared on fetch grant or when if_req low in IDLE.
REQ-026 d_load_req and d_store_req both high SHALL be treated as store only; load ignored.
REQ-027 GRANT_*: load_en/store_en held high with m_addr/m_wdata stable until m_ready sampled high; then strobes drop next cycle, m_rdata captured, go to ACK.
REQ-028 ACK: exactly one of if_ack/d_ack high for one cycle with captured read data on if_rdata/d_rdata; next state IDLE.
REQ-029 Minimum latency: request seen in IDLE at cycle N -> strobe high N+1 -> m_ready at N+1 -> ack at N+2; new arbitration at N+3.
REQ-030 Granted transaction SHALL complete even if requester deasserts before ack; no retraction.
REQ-031 m_ready high outside GRANT_* SHALL be ignored.
REQ-032 Store: store_en high, load_en low; d_rdata after a store ack SHALL be 0.
REQ-033 if_rdata/d_rdata hold last value except when updated at ACK entry; acks never both high.
REQ-034 m_wdata SHALL be 0 during fetch and load accesses.

Reset
REQ-035 rst high at any edge, including mid-transaction: state IDLE, starve_cnt 0, all outputs 0 next cycle; in-flight access abandoned, no ack issued.
REQ-036 First arbitration SHALL occur in the first cycle with rst low.

Verification
REQ-037 if_req=1, if_addr=0x100, m_ready=1 always, m_rdata=0xDEADBEEF -> load_en high 1 cycle at 0x100, if_ack with if_rdata=0xDEADBEEF two cycles after request.
REQ-038 if_req and d_load_req same cycle, d_addr=0x2000 -> data served first, fetch served next; if_ack never precedes d_ack.
REQ-039 d_store_req held continuously, if_req held, STARVE_MAX=4 -> exactly 4 store grants, then one fetch grant, pattern repeats.
REQ-040 d_store_req, d_addr=0x40, d_wdata=0x12345678, m_ready low 3 cycles -> store_en/m_addr/m_wdata stable 4 cycles, d_ack one cycle after m_ready.
REQ-041 rst asserted while in GRANT_D with m_ready low -> next cycle store_en=0, busy=0, no d_ack; later request served normally.
REQ-042 d_load_req and d_store_req both high -> only store_en pulses, single d_ack, d_rdata=0.
